// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: wrapper status encoding, arbiter FSM
// states, port indices and default bus widths.
package sram_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    SRAM_FREE   = 2'b00,
    SRAM_BUSY   = 2'b01,
    SRAM_ACCESS = 2'b10,
    SRAM_ERROR  = 2'b11
  } sram_state_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } arb_state_e;

  // The owner flag names the port that was granted most recently.
  localparam logic OWNER_HOST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

endpackage

// File: rtl/sram_arbiter_rr.sv
// Two-requester round-robin: combinational grant, registered last-owner flag.
// Bit 0 is the host port, bit 1 the inference-datapath port.
module rr_arbiter2
  import sram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       owner
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (owner == OWNER_DATA) ? 2'b01 : 2'b10;
    end
  end

  // Datapath as reset owner makes the host the first winner on a tie.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      owner <= OWNER_DATA;
    end else if (accept) begin
      owner <= grant[1];
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM wrapper between the host bus and the inference datapath,
// keeping exactly one transaction outstanding.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              h_req,
  input  logic              h_wen,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_done,
  output logic              h_err,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] address,
  output logic              read_enable,
  output logic              write_enable,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic [1:0]        sram_state
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  arb_state_e        state;
  logic              wen_q;
  logic              done_q;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        grant;
  logic              owner;
  logic              sram_free;
  logic              accept;
  logic              wait_err;
  logic              win_wen;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign sram_free = (sram_state == SRAM_FREE);

  // Grant is a same-cycle pulse; gating with n_rst keeps it low during reset.
  assign accept = n_rst && (state == ST_IDLE) && (h_req || d_req) && sram_free;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .n_rst  (n_rst),
    .req    ({d_req, h_req}),
    .accept (accept),
    .grant  (grant),
    .owner  (owner)
  );

  assign win_wen   = grant[1] ? d_wen   : h_wen;
  assign win_addr  = grant[1] ? d_addr  : h_addr;
  assign win_wdata = grant[1] ? d_wdata : h_wdata;

  // A FREE wrapper always completes the access, even on the last WAIT cycle.
  assign wait_err = (state == ST_WAIT) && !sram_free &&
                    ((sram_state == SRAM_ERROR) || (cnt == CNT_MAX));

  assign h_gnt  = accept & grant[0];
  assign d_gnt  = accept & grant[1];
  assign h_err  = wait_err & (owner == OWNER_HOST);
  assign d_err  = wait_err & (owner == OWNER_DATA);
  assign h_done = done_q & (owner == OWNER_HOST);
  assign d_done = done_q & (owner == OWNER_DATA);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      wen_q        <= 1'b0;
      done_q       <= 1'b0;
      cnt          <= '0;
      address      <= '0;
      write_data   <= '0;
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      h_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wen_q        <= win_wen;
            address      <= win_addr;
            write_data   <= win_wdata;
            read_enable  <= ~win_wen;
            write_enable <= win_wen;
            cnt          <= '0;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          read_enable  <= 1'b0;
          write_enable <= 1'b0;
          state        <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sram_free) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
            if (!wen_q) begin
              if (owner == OWNER_DATA) begin
                d_rdata <= read_data;
              end else begin
                h_rdata <= read_data;
              end
            end
          end else if (wait_err) begin
            state <= ST_IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized and directed bench for sram_arbiter against a transaction-level
// model of arbitration order, completion latency and memory contents.
module tb_sram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          h_req, h_wen, d_req, d_wen;
  logic [AW-1:0] h_addr, d_addr;
  logic [DW-1:0] h_wdata, d_wdata;
  logic          h_gnt, h_done, h_err, d_gnt, d_done, d_err;
  logic [DW-1:0] h_rdata, d_rdata;
  logic [AW-1:0] address;
  logic          read_enable, write_enable;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic [1:0]    sram_state;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst),
    .h_req(h_req), .h_wen(h_wen), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_done(h_done), .h_err(h_err), .h_rdata(h_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .address(address), .read_enable(read_enable), .write_enable(write_enable),
    .write_data(write_data), .read_data(read_data), .sram_state(sram_state)
  );

  // Wrapper stand-in: BUSY during the strobe cycle plus cfg_busy-1 more cycles.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  int            busy_cnt;
  int            cfg_busy;
  bit            err_force;

  assign sram_state = err_force ? 2'b11 :
                      ((read_enable || write_enable || (busy_cnt != 0)) ? 2'b01 : 2'b00);

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_cnt  <= 0;
      read_data <= '0;
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] <= '0;
    end else if (write_enable || read_enable) begin
      if (write_enable) sram_mem[address] <= write_data;
      else read_data <= sram_mem[address];
      busy_cnt <= cfg_busy - 1;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            exp_last_data;
  logic [DW-1:0] exp_rdata [2];
  bit            pend [2];
  bit            p_wen [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  int            passed;
  int            total;
  int            served [2];

  task automatic applyStimulus();
    h_req = pend[0]; h_wen = p_wen[0]; h_addr = p_addr[0]; h_wdata = p_wdata[0];
    d_req = pend[1]; d_wen = p_wen[1]; d_addr = p_addr[1]; d_wdata = p_wdata[1];
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic checkAllZero(input string where);
    checkOutput({where, "_gnt"}, {h_gnt, d_gnt}, 0);
    checkOutput({where, "_done"}, {h_done, d_done}, 0);
    checkOutput({where, "_err"}, {h_err, d_err}, 0);
    checkOutput({where, "_strobes"}, {read_enable, write_enable}, 0);
    checkOutput({where, "_address"}, address, 0);
    checkOutput({where, "_write_data"}, write_data, 0);
    checkOutput({where, "_h_rdata"}, h_rdata, 0);
    checkOutput({where, "_d_rdata"}, d_rdata, 0);
  endtask

  task automatic resetModel();
    exp_last_data = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
  endtask

  task automatic setPending(input int p, input bit wen, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p] = 1'b1; p_wen[p] = wen; p_addr[p] = a; p_wdata[p] = d;
  endtask

  // Serves one transaction from the pending set; busy counts wrapper BUSY
  // cycles starting with the strobe cycle. abort_k>0 pulls reset in that cycle.
  task automatic serveNext(input int busy, input bit force_err, input int abort_k, input int max_wait);
    int w, endk, guard;
    bit is_done, wen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    cfg_busy = busy;
    @(negedge clk);
    err_force = 1'b0;
    applyStimulus();
    #1;
    guard = 0;
    while (sram_state != 2'b00 && guard < 200) begin
      checkOutput("gnt_while_not_free", {h_gnt, d_gnt}, 0);
      @(negedge clk);
      #1;
      guard++;
    end
    checkOutput("grant_wait_bound", guard > max_wait, 0);
    w = (pend[0] && pend[1]) ? (exp_last_data ? 0 : 1) : (pend[1] ? 1 : 0);
    checkOutput("h_gnt", h_gnt, w == 0);
    checkOutput("d_gnt", d_gnt, w == 1);
    wen = p_wen[w]; a = p_addr[w]; d = p_wdata[w];
    exp_last_data = (w == 1);
    if (wen) ref_mem[a] = d;
    if (force_err) begin
      endk = 2; is_done = 1'b0;
    end else if (busy <= TO) begin
      endk = busy + 2; is_done = 1'b1;
    end else begin
      endk = TO + 1; is_done = 1'b0;
    end
    for (int k = 1; k <= endk; k++) begin
      @(negedge clk);
      if (k == 1) begin
        pend[w] = 1'b0;
        applyStimulus();
      end
      if (force_err) err_force = (k == 2);
      #1;
      if (k == abort_k) begin
        #2 n_rst = 1'b0;
        #1;
        checkAllZero("async_reset");
        resetModel();
        return;
      end
      checkOutput("gnt_during_txn", {h_gnt, d_gnt}, 0);
      checkOutput("read_enable", read_enable, (k == 1) && !wen);
      checkOutput("write_enable", write_enable, (k == 1) && wen);
      checkOutput("address", address, a);
      checkOutput("write_data", write_data, d);
      checkOutput("h_done", h_done, (w == 0) && is_done && (k == endk));
      checkOutput("d_done", d_done, (w == 1) && is_done && (k == endk));
      checkOutput("h_err", h_err, (w == 0) && !is_done && (k == endk));
      checkOutput("d_err", d_err, (w == 1) && !is_done && (k == endk));
      if (k == endk) begin
        if (is_done && !wen) exp_rdata[w] = ref_mem[a];
        checkOutput("h_rdata", h_rdata, exp_rdata[0]);
        checkOutput("d_rdata", d_rdata, exp_rdata[1]);
      end
    end
    served[w]++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    passed = 0; total = 0;
    err_force = 1'b0; cfg_busy = 1;
    served[0] = 0; served[1] = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; p_wen[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
    end
    applyStimulus();
    resetModel();
    #12;
    checkAllZero("reset_state");
    @(negedge clk) n_rst = 1'b1;

    // Simultaneous requests, each port three times: host first, then alternate.
    setPending(0, 1'b1, 10'h010, $urandom);
    setPending(1, 1'b1, 10'h011, $urandom);
    for (int i = 0; i < 6; i++) begin
      serveNext($urandom_range(1, 3), 1'b0, 0, 0);
      if (exp_last_data) begin
        if (served[1] < 3) setPending(1, $urandom_range(0, 1), 10'(16 + i), $urandom);
      end else begin
        if (served[0] < 3) setPending(0, $urandom_range(0, 1), 10'(24 + i), $urandom);
      end
    end

    // Host write then read-back at 0x005; two BUSY cycles gives done at gnt+4.
    setPending(0, 1'b1, 10'h005, 32'hDEADBEEF);
    serveNext(2, 1'b0, 0, 0);
    setPending(0, 1'b0, 10'h005, $urandom);
    serveNext(1, 1'b0, 0, 0);

    // Wrapper ERROR during a datapath read; IDLE must regrant the next cycle.
    setPending(1, 1'b0, 10'h005, $urandom);
    serveNext(2, 1'b1, 0, 0);
    setPending(0, 1'b0, 10'h005, $urandom);
    serveNext(1, 1'b0, 0, 0);

    // Timeout: BUSY through all TO cycles of WAIT, then a normal read-back.
    setPending(0, 1'b1, 10'h007, 32'hA5A5_0007);
    serveNext(TO + 1, 1'b0, 0, 0);
    setPending(1, 1'b0, 10'h007, $urandom);
    serveNext(1, 1'b0, 0, 5);

    for (int i = 0; i < 40; i++) begin
      int mask;
      mask = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        if (mask[p] && !pend[p]) setPending(p, $urandom_range(0, 1), 10'($urandom_range(0, 15)), $urandom);
      end
      serveNext($urandom_range(1, 4), 1'b0, 0, 0);
    end
    while (pend[0] || pend[1]) serveNext($urandom_range(1, 4), 1'b0, 0, 0);

    // Reset in the middle of WAIT, then a tie must go to the host.
    setPending(0, 1'b0, 10'h005, $urandom);
    serveNext(8, 1'b0, 3, 0);
    @(negedge clk);
    checkAllZero("held_reset");
    n_rst = 1'b1;
    setPending(0, 1'b0, 10'h005, $urandom);
    setPending(1, 1'b1, 10'h009, $urandom);
    serveNext(1, 1'b0, 0, 0);
    serveNext(1, 1'b0, 0, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, 10, SRAM word address width.
REQ-002 Parameter DATA_W, 32, SRAM word data width.
REQ-003 Parameter TIMEOUT, 64, max cycles spent in WAIT before an error is flagged.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 h_req / h_wen  input  1/1  host-port (bus side) request; write when h_wen=1, read when h_wen=0.
REQ-007 h_addr / h_wdata  input  ADDR_W/DATA_W  host-port address and write data.
REQ-008 h_gnt / h_done / h_err  output  1/1/1  host-port grant, completion and error pulses.
REQ-009 h_rdata  output  DATA_W  host-port read data.
REQ-010 d_req, d_wen, d_addr, d_wdata, d_gnt, d_done, d_err, d_rdata: the inference-datapath port, with the same widths and meanings as the host port.
REQ-011 address  output  ADDR_W  SRAM wrapper address.
REQ-012 read_enable / write_enable  output  1/1  SRAM wrapper strobes.
REQ-013 write_data  output  DATA_W  to SRAM wrapper.
REQ-014 read_data  input  DATA_W  from SRAM wrapper.
REQ-015 sram_state  input  2  wrapper status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, DONE; exactly one transaction is outstanding at any time.
REQ-017 IDLE -> ISSUE when at least one req is high and sram_state==FREE.
- The winner's gnt pulses for one cycle in that same cycle.
- The winner's wen, addr and wdata are registered in that same cycle.
REQ-018 Arbitration is round-robin using a 1-bit last-owner flag.
- Reset value of the flag selects the host port as first winner.
- On simultaneous requests, the port that was not the last owner wins.
- A lone request always wins.
REQ-019 ISSUE lasts exactly one cycle.
- Exactly one of read_enable or write_enable is high, per the registered wen.
- address and write_data are driven from the registers.
- Next state is WAIT.
REQ-020 In WAIT, both strobes are low and address/write_data are held.
- sram_state==FREE -> DONE.
- sram_state==ERROR -> IDLE with owner err pulsing one cycle.
- Counter reaching TIMEOUT-1 -> IDLE with owner err pulsing one cycle.
REQ-021 DONE lasts exactly one cycle; owner done pulses; next state is IDLE.
- For reads, owner rdata is loaded from read_data on entry to DONE and holds until the next read completion on that port.
REQ-022 Minimum latency from req sampled in IDLE to done is 3 cycles (the gnt cycle plus 3).
REQ-023 A requester holds req, wen, addr and wdata stable until gnt.
- req still high after done is a new request.
- Back-to-back: IDLE may regrant in the cycle after DONE.
REQ-024 A request arriving while not in IDLE waits; no request is dropped.
REQ-025 The non-owner port's gnt, done and err stay 0 throughout another port's transaction.
REQ-026 The WAIT counter clears on entry to ISSUE and saturates at TIMEOUT-1.

Reset
REQ-027 On n_rst low, immediately:
- state=IDLE; last-owner flag = datapath, so the host wins first.
- All gnt, done, err, read_enable and write_enable are 0.
- address, write_data, h_rdata and d_rdata are 0; counter is 0.
REQ-028 Reset mid-transaction abandons it with no done or err pulse; the SRAM wrapper is reset by the same n_rst.

Structure
REQ-029 The shared package holds the sram_state encoding enum, the FSM state enum and the ADDR_W/DATA_W defaults; the accelerator top and the wrapper import it.
REQ-030 One sub-module, rr_arbiter2 (2-requester round-robin, combinational grant plus registered owner flag), is instantiated once.

Verification
REQ-031 Host write addr 0x005, data 0xDEADBEEF, wrapper FREE after 2 BUSY cycles.
- h_gnt pulses once, then write_enable for 1 cycle at address 0x005; h_done 4 cycles after the gnt cycle.
REQ-032 Host read addr 0x005 after REQ-031.
- h_rdata=0xDEADBEEF at h_done; d_* outputs stay 0.
REQ-033 h_req and d_req rise in the same cycle after reset, each repeated 3 times.
- Grants alternate H, D, H, D, H, D; no port is granted twice in a row while the other is pending.
REQ-034 Wrapper forced to ERROR during WAIT on a datapath read.
- d_err pulses once, no d_done, FSM back in IDLE next cycle.
REQ-035 Wrapper held BUSY for TIMEOUT cycles.
- Owner err pulses in cycle TIMEOUT of WAIT; a following request is served normally.
REQ-036 n_rst asserted during WAIT.
- All outputs 0 asynchronously; after release a host request is granted first.
